// File: rtl/l16b_sequencer.sv
// l16b_sequencer: multi-cycle sequencer for the 16-byte load instructions.
//   L16BW (mode 2'b10): four word reads written to consecutive registers.
//   L16BF (mode 2'b11): four word reads packed into a 128-bit window buffer.
// Optional feature: define L16B_TIMEOUT_EN to add an ack-wait timeout that
// aborts the sequence and pulses the extra 'error' output.
module l16b_sequencer #(
  parameter int BEATS = 4
`ifdef L16B_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [31:0]  base_addr,
  input  logic [4:0]   dest_reg,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata,
  output logic         reg_wr_en,
  output logic [4:0]   reg_wr_addr,
  output logic [31:0]  reg_wr_data,
  output logic [127:0] buffer,
  output logic         buffer_valid,
  output logic         stall,
  output logic         busy,
  output logic         done
`ifdef L16B_TIMEOUT_EN
  ,
  output logic         error
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  state_t      state;
  logic        fmode;     // latched mode[0]: 1 = L16BF (buffer), 0 = L16BW (registers)
  logic [4:0]  dest_q;
  logic [1:0]  beat;
  logic        accept;
  logic [4:0]  wr_addr;

`ifdef L16B_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt;
`endif

  // Accept only real L16B codes; the stall term must be combinational so the
  // pipeline freezes in the very cycle the request is presented.
  assign accept  = (state == IDLE) && start && mode[1];
  assign stall   = accept || (state != IDLE);
  assign busy    = (state != IDLE);
  // Destination index wraps naturally at 5 bits (r31 -> r0).
  assign wr_addr = dest_q + {3'b000, beat};

  // Sequencer FSM with registered memory, register-file and buffer outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      fmode        <= 1'b0;
      dest_q       <= 5'd0;
      beat         <= 2'd0;
      mem_req      <= 1'b0;
      mem_addr     <= 32'd0;
      reg_wr_en    <= 1'b0;
      reg_wr_addr  <= 5'd0;
      reg_wr_data  <= 32'd0;
      buffer       <= 128'd0;
      buffer_valid <= 1'b0;
      done         <= 1'b0;
`ifdef L16B_TIMEOUT_EN
      wait_cnt     <= '0;
      error        <= 1'b0;
`endif
    end else begin
      reg_wr_en <= 1'b0;
      done      <= 1'b0;
`ifdef L16B_TIMEOUT_EN
      error     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= REQ;
            fmode        <= mode[0];
            dest_q       <= dest_reg;
            beat         <= 2'd0;
            mem_req      <= 1'b1;
            // Force word alignment of the effective address.
            mem_addr     <= base_addr & 32'hFFFF_FFFC;
            buffer_valid <= 1'b0;
`ifdef L16B_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
          end
        end

        REQ: begin
          if (mem_ack) begin
            if (fmode) begin
              buffer[{beat, 5'b00000} +: 32] <= mem_rdata;
            end else begin
              // Writes to r0 are dropped but the beat still advances.
              reg_wr_en   <= (wr_addr != 5'd0);
              reg_wr_addr <= wr_addr;
              reg_wr_data <= mem_rdata;
            end
            if (beat == LAST_BEAT) begin
              state   <= FIN;
              mem_req <= 1'b0;
              done    <= 1'b1;
              if (fmode) begin
                buffer_valid <= 1'b1;
              end
            end else begin
              beat     <= beat + 2'd1;
              mem_addr <= mem_addr + 32'd4;
            end
`ifdef L16B_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            // Memory never answered: abandon the sequence without writes.
            state    <= IDLE;
            mem_req  <= 1'b0;
            done     <= 1'b1;
            error    <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l16b_sequencer.sv
// tb_l16b_sequencer: directed bench for l16b_sequencer. A per-transaction
// timeline model is derived from the ack schedule and checked every cycle;
// literal expectations pin the key cycle numbers and final values.
`timescale 1ns/1ps
module tb_l16b_sequencer;

  localparam int MAXC = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [31:0]  base_addr;
  logic [4:0]   dest_reg;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         reg_wr_en;
  logic [4:0]   reg_wr_addr;
  logic [31:0]  reg_wr_data;
  logic [127:0] buffer;
  logic         buffer_valid;
  logic         stall;
  logic         busy;
  logic         done;
`ifdef L16B_TIMEOUT_EN
  logic         error;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Timeline model for the current transaction, indexed by cycle from accept.
  bit           exp_stall [MAXC];
  bit           exp_busy  [MAXC];
  bit           exp_req   [MAXC];
  logic [31:0]  exp_addr  [MAXC];
  bit           exp_we    [MAXC];
  logic [4:0]   exp_wa    [MAXC];
  logic [31:0]  exp_wd    [MAXC];
  bit           exp_done  [MAXC];
  bit           exp_bv    [MAXC];
  bit           exp_bchk  [MAXC];
  logic [127:0] exp_buf   [MAXC];

  bit           chk_on;
  int           cur_c;
  bit           model_bv;
  logic [127:0] model_buf;

  int           obs_done, obs_we_n, obs_we_first, obs_we_last, obs_stall_last;
  logic [31:0]  obs_addr_last;

  always #5 clk = ~clk;

`ifdef L16B_TIMEOUT_EN
  l16b_sequencer #(.BEATS(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .dest_reg(dest_reg), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .buffer(buffer), .buffer_valid(buffer_valid),
    .stall(stall), .busy(busy), .done(done), .error(error)
  );
`else
  l16b_sequencer #(.BEATS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .dest_reg(dest_reg), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .buffer(buffer), .buffer_valid(buffer_valid),
    .stall(stall), .busy(busy), .done(done)
  );
`endif

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (c=%0d): got %0h, expected %0h", name, cur_c, act, exp);
    end
  endtask

  // Compare process: outputs against the timeline model on every active cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("stall", stall, exp_stall[cur_c]);
      chk("busy", busy, exp_busy[cur_c]);
      chk("mem_req", mem_req, exp_req[cur_c]);
      if (exp_req[cur_c]) chk("mem_addr", mem_addr, exp_addr[cur_c]);
      chk("reg_wr_en", reg_wr_en, exp_we[cur_c]);
      if (exp_we[cur_c]) begin
        chk("reg_wr_addr", reg_wr_addr, exp_wa[cur_c]);
        chk("reg_wr_data", reg_wr_data, exp_wd[cur_c]);
      end
      chk("done", done, exp_done[cur_c]);
      chk("buffer_valid", buffer_valid, exp_bv[cur_c]);
      if (exp_bchk[cur_c]) chk("buffer", buffer, exp_buf[cur_c]);
      if (done) obs_done = cur_c;
      if (reg_wr_en) begin
        if (obs_we_n == 0) obs_we_first = cur_c;
        obs_we_last = cur_c;
        obs_we_n++;
      end
      if (stall) obs_stall_last = cur_c;
      if (mem_req) obs_addr_last = mem_addr;
    end
  end

  // One L16B transaction; w = wait cycles before each ack, tie = hold ack high
  // in every cycle, stop_c >= 0 stops the transaction (unchecked) at that cycle.
  task automatic run_txn(input logic [1:0] m, input logic [31:0] base, input logic [4:0] dest,
                         input logic [127:0] data, input int w, input bit tie, input int stop_c);
    int a [4];
    int fin, last, k;
    bit is_f;
    logic [4:0] wa;
    is_f = m[0];
    for (int i = 0; i < 4; i++) a[i] = 1 + i * (w + 1) + w;
    fin  = a[3] + 1;
    last = fin + 2;
    for (int c = 0; c <= last; c++) begin
      exp_stall[c] = (c <= fin);
      exp_busy[c]  = (c >= 1) && (c <= fin);
      exp_req[c]   = (c >= 1) && (c <= a[3]);
      k = 0;
      while (k < 3 && c > a[k]) k++;
      exp_addr[c]  = (base & 32'hFFFF_FFFC) + 32'(4 * k);
      exp_done[c]  = (c == fin);
      exp_we[c]    = 1'b0;
      exp_wa[c]    = 5'd0;
      exp_wd[c]    = 32'd0;
      for (int i = 0; i < 4; i++) begin
        wa = dest + 5'(i);
        if (!is_f && c == a[i] + 1 && wa != 5'd0) begin
          exp_we[c] = 1'b1;
          exp_wa[c] = wa;
          exp_wd[c] = data[32*i +: 32];
        end
      end
      exp_bv[c]   = (c == 0) ? model_bv : (is_f && c >= fin);
      exp_bchk[c] = !is_f || (c >= fin);
      exp_buf[c]  = is_f ? data : model_buf;
    end
    obs_done = -1; obs_we_n = 0; obs_we_first = -1; obs_we_last = -1;
    obs_stall_last = -1; obs_addr_last = 32'hX;
    for (int c = 0; c <= last; c++) begin
      cur_c     = c;
      chk_on    = (stop_c < 0) || (c < stop_c);
      start     = (c == 0);
      mode      = (c == 0) ? m : 2'b00;
      base_addr = base;
      dest_reg  = dest;
      mem_ack   = tie;
      mem_rdata = 32'hDEAD_0000 | 32'(c);
      for (int i = 0; i < 4; i++) begin
        if (c == a[i]) begin
          mem_ack   = 1'b1;
          mem_rdata = data[32*i +: 32];
        end
      end
      if (c == stop_c) return;
      @(posedge clk); #1;
    end
    chk_on    = 1'b0;
    mem_ack   = 1'b0;
    model_bv  = is_f;
    if (is_f) model_buf = data;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; base_addr = 32'd0; dest_reg = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0; chk_on = 1'b0; cur_c = 0;
    model_bv = 1'b0; model_buf = 128'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_req", mem_req, 0);
    chk("reset stall", stall, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset reg_wr_en", reg_wr_en, 0);
    chk("reset buffer", buffer, 0);
    chk("reset buffer_valid", buffer_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // L16BW, ack tied high, r8..r11.
    run_txn(2'b10, 32'h0000_0100, 5'd8,
            {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, 1'b1, -1);
    chk("t1 done cycle", obs_done, 5);
    chk("t1 first write cycle", obs_we_first, 2);
    chk("t1 last write cycle", obs_we_last, 5);
    chk("t1 write count", obs_we_n, 4);
    chk("t1 last stall cycle", obs_stall_last, 5);
    chk("t1 last mem_addr", obs_addr_last, 32'h0000_010C);

    // L16BF, misaligned base, two wait cycles per beat.
    run_txn(2'b11, 32'h0000_0203, 5'd0,
            {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 2, 1'b0, -1);
    chk("t2 buffer", buffer, 128'h44444444_33333333_22222222_11111111);
    chk("t2 buffer_valid held", buffer_valid, 1);
    chk("t2 write count", obs_we_n, 0);
    chk("t2 done cycle", obs_done, 13);
    chk("t2 last mem_addr", obs_addr_last, 32'h0000_020C);

    // L16BW register wrap r30, r31, (r0 suppressed), r1.
    run_txn(2'b10, 32'h0000_0040, 5'd30,
            {32'h33, 32'h32, 32'h31, 32'h30}, 0, 1'b0, -1);
    chk("t3 write count", obs_we_n, 3);
    chk("t3 done cycle", obs_done, 5);
    chk("t3 buffer untouched", buffer, 128'h44444444_33333333_22222222_11111111);

    // Address wrap through 2^32.
    run_txn(2'b11, 32'hFFFF_FFF8, 5'd0,
            {32'h8, 32'h7, 32'h6, 32'h5}, 1, 1'b0, -1);
    chk("t4 last mem_addr", obs_addr_last, 32'h0000_0004);
    chk("t4 done cycle", obs_done, 9);

    // Reset during beat 2 of an L16BW with ack tied high.
    run_txn(2'b10, 32'h0000_0300, 5'd4,
            {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 0, 1'b1, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("abort mem_req", mem_req, 0);
    chk("abort stall", stall, 0);
    chk("abort busy", busy, 0);
    chk("abort reg_wr_en", reg_wr_en, 0);
    chk("abort buffer", buffer, 0);
    chk("abort buffer_valid", buffer_valid, 0);
    model_bv = 1'b0; model_buf = 128'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post-abort reg_wr_en", reg_wr_en, 0);
      chk("post-abort mem_req", mem_req, 0);
    end
    mem_ack = 1'b0;
    @(posedge clk); #1;

    // Start with a no-op code must not stall.
    start = 1'b1; mode = 2'b01;
    #1;
    chk("noop stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; mode = 2'b00;
    chk("noop busy", busy, 0);
    @(negedge clk);
    chk("noop mem_req", mem_req, 0);
    @(posedge clk); #1;

`ifdef L16B_TIMEOUT_EN
    begin
      int err_c, done_c, req_last, we_n;
      err_c = -1; done_c = -1; req_last = -1; we_n = 0;
      for (int c = 0; c < 14; c++) begin
        cur_c = c;
        start = (c == 0); mode = (c == 0) ? 2'b10 : 2'b00;
        base_addr = 32'h0000_0500; dest_reg = 5'd3; mem_ack = 1'b0;
        @(negedge clk);
        if (error) err_c = c;
        if (done) done_c = c;
        if (mem_req) req_last = c;
        if (reg_wr_en) we_n++;
        if (c == 9) chk("timeout busy", busy, 0);
        @(posedge clk); #1;
      end
      chk("timeout error cycle", err_c, 9);
      chk("timeout done cycle", done_c, 9);
      chk("timeout last mem_req", req_last, 8);
      chk("timeout writes", we_n, 0);
      chk("timeout buffer_valid", buffer_valid, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/l16b_sequencer.md
Name: l16b_sequencer

Overview:
Multi-cycle sequencer for the custom 16-byte load instructions L16BW (L16B code 2'b10) and L16BF (L16B code 2'b11).
- Accepts a decoded L16B request from the EX stage and stalls the pipeline.
- Issues four consecutive word reads to data memory over a req/ack handshake.
- L16BW: writes the four words to consecutive registers.
- L16BF: packs the four words into a 128-bit window buffer for the compare datapath.

Parameters:
- BEATS, 4, number of word reads per instruction (fixed at 4 for 16 bytes).
- TIMEOUT, 255, ack-wait cycle limit (used only with the optional feature).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle request strobe from EX.
- Mode  in  2  L16B code: 10 = L16BW, 11 = L16BF; 00/01 = no-op.
- BaseAddr  in  32  effective address (rs + imm) from the ALU.
- DestReg  in  5  first destination register (rt).
- MemReq  out  1  memory read request.
- MemAddr  out  32  word address of the current beat.
- MemAck  in  1  memory accepted the request; MemRdata valid this cycle.
- MemRdata  in  32  read data.
- RegWrEn  out  1  register-file write strobe (L16BW only).
- RegWrAddr  out  5  register-file write address.
- RegWrData  out  32  register-file write data.
- Buffer  out  128  window buffer (L16BF).
- BufferValid  out  1  Buffer holds a complete L16BF result.
- Stall  out  1  freeze PC, IF/ID and ID/EX.
- Busy  out  1  sequence in progress.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, active-high): state IDLE. All outputs 0, Buffer = 0, beat counter = 0. Reset mid-sequence aborts immediately: MemReq drops, no further register writes.
- States:
  - IDLE: Start && Mode[1] accepts; latch Mode, BaseAddr with bits [1:0] forced to 00, DestReg; beat = 0; go to REQ. Start with Mode 00/01 is ignored (no stall).
  - REQ: MemReq = 1, MemAddr = base + 4*beat (mod 2^32). MemReq and MemAddr are held stable until MemAck. On MemAck: capture data; if beat == 3 go to FIN, else beat++ and stay in REQ. MemAck in the cycle REQ is entered is legal, so the minimum is 1 cycle per beat.
  - FIN: one cycle; Done = 1; return to IDLE.
- Stall = (IDLE && Start && Mode[1]) || state != IDLE. The combinational term holds the pipeline from the accept cycle onward. Busy = state != IDLE.
- Writes, L16BW:
  - Each acked beat k produces a registered RegWrEn pulse the next cycle, with RegWrAddr = (DestReg + k) mod 32 and RegWrData = captured word.
  - Address wrap 31 -> 0 is legal.
  - A write targeting register 0 is suppressed (RegWrEn stays 0) but the beat still counts.
- Buffer, L16BF:
  - Word k goes into Buffer[32k+31:32k]; RegWrEn never asserts.
  - BufferValid is set in the FIN cycle, holds until the next accepted Start (cleared on accept), and is cleared by Reset.
- Timing with ack in every first cycle: accept at cycle 0; MemReq cycles 1-4; RegWrEn cycles 2-5; FIN/Done cycle 5; Stall low from cycle 6.
- Start while Busy is ignored; the pipeline is stalled, so this is not expected.
- MemAck while not in REQ is ignored.

Optional Feature:
- Macro: L16B_TIMEOUT_EN.
- Defined: adds a wait counter and an output Error (1 bit, reset 0).
  - Counter clears on each MemAck or new beat and counts cycles in REQ without MemAck.
  - On reaching TIMEOUT: drop MemReq, pulse Error and Done for one cycle, and return to IDLE.
  - No further writes occur; BufferValid stays 0.
- Not defined: no Error port; REQ waits indefinitely for MemAck.

Test Plan:
- Reset, then L16BW: DestReg = 8, BaseAddr = 0x100, MemAck tied 1, data 0xA0..0xA3 -> MemAddr 0x100/0x104/0x108/0x10C; RegWrEn cycles 2-5 writing r8..r11 = 0xA0..0xA3; Done cycle 5; Stall high cycles 0-5.
- L16BF: BaseAddr = 0x203 (misaligned), data 0x11111111..0x44444444, MemAck after 2 wait cycles per beat -> MemAddr starts 0x200; Buffer = 0x44444444_33333333_22222222_11111111; BufferValid = 1 at FIN; RegWrEn never 1.
- Register wrap: L16BW with DestReg = 30 -> writes r30, r31; r0 write suppressed; r1 written; Done after 4 beats.
- Address wrap: BaseAddr = 0xFFFFFFF8 -> MemAddr FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- Reset asserted during beat 2 -> MemReq and Stall drop asynchronously, no further RegWrEn, Buffer/BufferValid = 0. A subsequent Start with Mode 01 -> no Stall, Busy stays 0.
- With L16B_TIMEOUT_EN and TIMEOUT = 8: MemAck held 0 -> Error and Done pulse 8 cycles into REQ; return to IDLE; no writes.
